// File: rtl/gelato_warp_scheduler.sv
// gelato_warp_scheduler: per-SM fetch arbiter.
// Picks one eligible warp per cycle (round-robin), drives a registered
// valid/ready request to instruction fetch and locks each issued warp until
// its split-table update comes back on done_valid/done_warp.
//
// Optional build macro: GELATO_SCHED_PERF_EN adds three 32-bit perf counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no request outstanding, fetch_valid=0
// ST_ISSUE | request presented to fetch, held until fetch_ready
module gelato_warp_scheduler #(
   parameter int WARP_NUM  = 4,
   parameter int WARP_ID_W = $clog2(WARP_NUM),
   parameter int PC_W      = 32,
   parameter int SPLIT_W   = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        rdy,
   input  logic [WARP_NUM-1:0]         warp_en,
   input  logic [WARP_NUM-1:0]         cand_valid,
   input  logic [WARP_NUM*PC_W-1:0]    cand_pc,
   input  logic [WARP_NUM*SPLIT_W-1:0] cand_split,
   output logic                        fetch_valid,
   input  logic                        fetch_ready,
   output logic [WARP_ID_W-1:0]        fetch_warp,
   output logic [PC_W-1:0]             fetch_pc,
   output logic [SPLIT_W-1:0]          fetch_split,
   input  logic                        done_valid,
   input  logic [WARP_ID_W-1:0]        done_warp,
   input  logic                        flush,
   output logic [WARP_NUM-1:0]         busy_mask
`ifdef GELATO_SCHED_PERF_EN
   ,
   output logic [31:0]                 perf_issue_cnt,
   output logic [31:0]                 perf_stall_cnt,
   output logic [31:0]                 perf_idle_cnt
`endif
);

   typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

   state_t                state_q, state_d;
   logic [WARP_NUM-1:0]   busy_q, busy_d;
   logic [WARP_ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic                  valid_d;
   logic [WARP_ID_W-1:0]  warp_d;
   logic [PC_W-1:0]       pc_d;
   logic [SPLIT_W-1:0]    split_d;

   logic [WARP_NUM-1:0]   elig;
   logic [WARP_NUM-1:0]   done_clr;
   logic                  found;
   logic [WARP_ID_W-1:0]  win;
   logic [WARP_ID_W-1:0]  idx;
   logic                  grant;

   // Eligibility always uses the registered lock bits, so a warp released
   // this cycle only competes from the next cycle on.
   assign elig      = warp_en & cand_valid & ~busy_q;
   assign busy_mask = busy_q;

   // Round-robin search: first eligible warp at or above rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < WARP_NUM; k++) begin
         idx = rr_ptr_q + WARP_ID_W'(k);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Release mask; a done for a warp that is not locked changes nothing.
   always_comb begin
      done_clr = '0;
      if (done_valid) begin
         done_clr[done_warp] = 1'b1;
      end
      done_clr = done_clr & busy_q;
   end

   // Next-state, lock and request-register logic.
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      rr_ptr_d = rr_ptr_q;
      valid_d  = fetch_valid;
      warp_d   = fetch_warp;
      pc_d     = fetch_pc;
      split_d  = fetch_split;
      grant    = 1'b0;
      if (rdy) begin
         if (flush) begin
            valid_d = 1'b0;
            busy_d  = '0;
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (found) begin
                     grant = 1'b1;
                  end
               end
               ST_ISSUE: begin
                  if (fetch_ready) begin
                     if (found) begin
                        grant = 1'b1;
                     end else begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                     end
                  end
               end
               default: begin
                  valid_d = 1'b0;
                  state_d = ST_IDLE;
               end
            endcase
            // Clear first, then set: a same-cycle grant to the released
            // warp must leave it locked.
            busy_d = busy_q & ~done_clr;
            if (grant) begin
               valid_d     = 1'b1;
               warp_d      = win;
               pc_d        = cand_pc[int'(win)*PC_W +: PC_W];
               split_d     = cand_split[int'(win)*SPLIT_W +: SPLIT_W];
               rr_ptr_d    = win + WARP_ID_W'(1);
               state_d     = ST_ISSUE;
               busy_d[win] = 1'b1;
            end
         end
      end
   end

   // State, lock bits, pointer and registered fetch request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         busy_q      <= '0;
         rr_ptr_q    <= '0;
         fetch_valid <= 1'b0;
         fetch_warp  <= '0;
         fetch_pc    <= '0;
         fetch_split <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         rr_ptr_q    <= rr_ptr_d;
         fetch_valid <= valid_d;
         fetch_warp  <= warp_d;
         fetch_pc    <= pc_d;
         fetch_split <= split_d;
      end
   end

`ifdef GELATO_SCHED_PERF_EN
   // Free-running wrap-around counters; they survive flush and freeze on rdy=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
         perf_idle_cnt  <= '0;
      end else if (rdy) begin
         if (fetch_valid && fetch_ready && !flush) begin
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         end
         if (fetch_valid && !fetch_ready) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if ((state_q == ST_IDLE) && (|warp_en)) begin
            perf_idle_cnt <= perf_idle_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// Directed bench for gelato_warp_scheduler (4 warps, 32-bit pc, 2-bit split).
// Warp w presents pc 0x1000 + w*0x100 and split 3-w.
module tb_gelato_warp_scheduler;

   localparam int WN  = 4;
   localparam int WIW = 2;
   localparam int PCW = 32;
   localparam int SPW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rdy;
   logic [WN-1:0]     warp_en;
   logic [WN-1:0]     cand_valid;
   logic [WN*PCW-1:0] cand_pc;
   logic [WN*SPW-1:0] cand_split;
   logic              fetch_valid;
   logic              fetch_ready;
   logic [WIW-1:0]    fetch_warp;
   logic [PCW-1:0]    fetch_pc;
   logic [SPW-1:0]    fetch_split;
   logic              done_valid;
   logic [WIW-1:0]    done_warp;
   logic              flush;
   logic [WN-1:0]     busy_mask;
`ifdef GELATO_SCHED_PERF_EN
   logic [31:0]       perf_issue_cnt;
   logic [31:0]       perf_stall_cnt;
   logic [31:0]       perf_idle_cnt;
   logic [31:0]       issue_snap;
`endif

   int errors = 0;
   int checks = 0;

   gelato_warp_scheduler #(
      .WARP_NUM (WN),
      .PC_W     (PCW),
      .SPLIT_W  (SPW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rdy         (rdy),
      .warp_en     (warp_en),
      .cand_valid  (cand_valid),
      .cand_pc     (cand_pc),
      .cand_split  (cand_split),
      .fetch_valid (fetch_valid),
      .fetch_ready (fetch_ready),
      .fetch_warp  (fetch_warp),
      .fetch_pc    (fetch_pc),
      .fetch_split (fetch_split),
      .done_valid  (done_valid),
      .done_warp   (done_warp),
      .flush       (flush),
      .busy_mask   (busy_mask)
`ifdef GELATO_SCHED_PERF_EN
      ,
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt),
      .perf_idle_cnt  (perf_idle_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_req(input string tag, input logic [1:0] w, input logic [31:0] pc,
                            input logic [1:0] sp);
      check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
      check({tag, "_warp"},  32'(fetch_warp),  32'(w));
      check({tag, "_pc"},    fetch_pc,         pc);
      check({tag, "_split"}, 32'(fetch_split), 32'(sp));
   endtask

   initial begin
      rdy         = 1'b1;
      warp_en     = '0;
      cand_valid  = '0;
      fetch_ready = 1'b0;
      done_valid  = 1'b0;
      done_warp   = '0;
      flush       = 1'b0;
      for (int w = 0; w < WN; w++) begin
         cand_pc[w*PCW +: PCW]    = 32'h1000 + 32'(w) * 32'h100;
         cand_split[w*SPW +: SPW] = 2'(3 - w);
      end

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(fetch_valid), 32'd0);
      check("rst_warp",  32'(fetch_warp),  32'd0);
      check("rst_pc",    fetch_pc,         32'd0);
      check("rst_split", 32'(fetch_split), 32'd0);
      check("rst_busy",  32'(busy_mask),   32'd0);
`ifdef GELATO_SCHED_PERF_EN
      check("rst_perf_issue", perf_issue_cnt, 32'd0);
`endif
      rst_n = 1'b1;

      // all warps eligible, back-to-back round robin 0,1,2,3,0
      warp_en = 4'b1111; cand_valid = 4'b1111; fetch_ready = 1'b1;
      tick(); check_req("rr0", 2'd0, 32'h1000, 2'd3); check("rr0_busy", 32'(busy_mask), 32'h1);
      tick(); check_req("rr1", 2'd1, 32'h1100, 2'd2); check("rr1_busy", 32'(busy_mask), 32'h3);
      done_valid = 1'b1; done_warp = 2'd0;
      tick(); check_req("rr2", 2'd2, 32'h1200, 2'd1); check("rr2_busy", 32'(busy_mask), 32'h6);
      done_warp = 2'd1;
      tick(); check_req("rr3", 2'd3, 32'h1300, 2'd0); check("rr3_busy", 32'(busy_mask), 32'hC);
      done_warp = 2'd2;
      tick(); check_req("rr4", 2'd0, 32'h1000, 2'd3); check("rr4_busy", 32'(busy_mask), 32'h9);
      done_warp = 2'd3; cand_valid = 4'b0000;
      tick(); check("rr_end_valid", 32'(fetch_valid), 32'd0); check("rr_end_busy", 32'(busy_mask), 32'h1);
      done_warp = 2'd0;
      tick(); check("rr_clear_busy", 32'(busy_mask), 32'h0);
      done_valid = 1'b0;

      // only warp 2, fetch stalled 3 cycles; warp_en drop does not cancel
      cand_valid = 4'b0100; fetch_ready = 1'b0;
      tick(); check_req("stall0", 2'd2, 32'h1200, 2'd1); check("stall0_busy", 32'(busy_mask), 32'h4);
      warp_en = 4'b1011;
      tick(); check_req("stall1", 2'd2, 32'h1200, 2'd1);
      warp_en = 4'b1111;
      tick(); check_req("stall2", 2'd2, 32'h1200, 2'd1);
      fetch_ready = 1'b1;
      tick(); check("stall_acc_valid", 32'(fetch_valid), 32'd0); check("stall_acc_busy", 32'(busy_mask), 32'h4);
      tick(); check("stall_noreissue", 32'(fetch_valid), 32'd0); check("stall_hold_busy", 32'(busy_mask), 32'h4);
      cand_valid = 4'b0000; done_valid = 1'b1; done_warp = 2'd2;
      tick(); check("stall_rel_busy", 32'(busy_mask), 32'h0);
      done_valid = 1'b0;

      // warp 1 locked: no reissue until released
      cand_valid = 4'b0010;
      tick(); check_req("lock0", 2'd1, 32'h1100, 2'd2); check("lock0_busy", 32'(busy_mask), 32'h2);
      tick(); check("lock_acc_valid", 32'(fetch_valid), 32'd0);
      tick(); check("lock_noreissue", 32'(fetch_valid), 32'd0); check("lock_busy", 32'(busy_mask), 32'h2);
      done_valid = 1'b1; done_warp = 2'd1;
      tick(); check("lock_rel_valid", 32'(fetch_valid), 32'd0); check("lock_rel_busy", 32'(busy_mask), 32'h0);
      // done still asserted for a now-idle warp while it is granted again: lock stays set
      tick(); check_req("lock_reissue", 2'd1, 32'h1100, 2'd2); check("lock_setwins", 32'(busy_mask), 32'h2);
      done_valid = 1'b0; cand_valid = 4'b0000;
      tick(); check("lock_end_valid", 32'(fetch_valid), 32'd0);
      done_valid = 1'b1; done_warp = 2'd1;
      tick(); check("lock_end_busy", 32'(busy_mask), 32'h0);
      done_valid = 1'b0;

      // pointer at 3 with {0,3} eligible: 3 then 0
      cand_valid = 4'b0100;
      tick(); check_req("wrap_pre", 2'd2, 32'h1200, 2'd1);
      cand_valid = 4'b1001;
      tick(); check_req("wrap0", 2'd3, 32'h1300, 2'd0); check("wrap0_busy", 32'(busy_mask), 32'hC);
      tick(); check_req("wrap1", 2'd0, 32'h1000, 2'd3); check("wrap1_busy", 32'(busy_mask), 32'hD);
      cand_valid = 4'b0010; done_valid = 1'b1; done_warp = 2'd2;
      tick(); check_req("fl_pre", 2'd1, 32'h1100, 2'd2); check("fl_pre_busy", 32'(busy_mask), 32'hB);

      // flush with pending request and busy=1011
      done_valid = 1'b0; fetch_ready = 1'b0; flush = 1'b1;
      tick(); check("flush_valid", 32'(fetch_valid), 32'd0); check("flush_busy", 32'(busy_mask), 32'h0);
      flush = 1'b0; cand_valid = 4'b1111;
      tick(); check_req("flush_rrkeep", 2'd2, 32'h1200, 2'd1); check("flush_rr_busy", 32'(busy_mask), 32'h4);

      // rdy=0 freezes everything, including done and fetch_ready
`ifdef GELATO_SCHED_PERF_EN
      issue_snap = perf_issue_cnt;
`endif
      rdy = 1'b0; fetch_ready = 1'b1; done_valid = 1'b1; done_warp = 2'd2;
      tick(); check_req("frz0", 2'd2, 32'h1200, 2'd1); check("frz0_busy", 32'(busy_mask), 32'h4);
      tick(); check_req("frz1", 2'd2, 32'h1200, 2'd1); check("frz1_busy", 32'(busy_mask), 32'h4);
`ifdef GELATO_SCHED_PERF_EN
      check("frz_perf_issue", perf_issue_cnt, issue_snap);
`endif
      rdy = 1'b1; done_valid = 1'b0; cand_valid = 4'b0000;
      tick(); check("thaw_valid", 32'(fetch_valid), 32'd0); check("thaw_busy", 32'(busy_mask), 32'h4);
`ifdef GELATO_SCHED_PERF_EN
      check("thaw_perf_issue", perf_issue_cnt, issue_snap + 32'd1);
`endif

      // async reset in the middle of a request
      cand_valid = 4'b0001;
      tick(); check_req("ar_pre", 2'd0, 32'h1000, 2'd3); check("ar_pre_busy", 32'(busy_mask), 32'h5);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(fetch_valid), 32'd0);
      check("ar_warp",  32'(fetch_warp),  32'd0);
      check("ar_pc",    fetch_pc,         32'd0);
      check("ar_split", 32'(fetch_split), 32'd0);
      check("ar_busy",  32'(busy_mask),   32'd0);
      #4 rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gelato_warp_scheduler.md
Name: gelato_warp_scheduler

Overview:
- Per-SM fetch arbiter. Each warp's split table presents one candidate (pc, split-table entry, valid) per cycle.
- The scheduler picks one eligible warp per cycle using round-robin. It drives a registered valid/ready request to instruction fetch.
- A warp is locked from the moment it is issued until the decode/execute path returns the split-table update for that warp. This prevents a stale PC from being issued twice.
- Sits between the per-warp split tables and the fetch stage.

Parameters:
- WARP_NUM, 4, number of warps arbitrated; power of two, 2..16.
- WARP_ID_W, $clog2(WARP_NUM), warp index width.
- PC_W, 32, program counter width.
- SPLIT_W, 2, split-table entry index width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- rdy  input  1  global enable; when 0, all state holds and no handshake completes.
- warp_en  input  WARP_NUM  warp launched and live (from init); bit i=0 makes warp i ineligible.
- cand_valid  input  WARP_NUM  split table i has an active, valid entry.
- cand_pc  input  WARP_NUM*PC_W  candidate pc; warp i occupies bits [i*PC_W +: PC_W].
- cand_split  input  WARP_NUM*SPLIT_W  candidate split-table entry number; same packing.
- fetch_valid  output  1  request to fetch is valid.
- fetch_ready  input  1  fetch accepts the request.
- fetch_warp  output  WARP_ID_W  issued warp id.
- fetch_pc  output  PC_W  issued pc.
- fetch_split  output  SPLIT_W  issued split-table entry.
- done_valid  input  1  split-table update for a previously issued warp has been applied.
- done_warp  input  WARP_ID_W  warp whose lock is released.
- flush  input  1  synchronous flush: drop the pending request and clear all locks.
- busy_mask  output  WARP_NUM  current lock bits (debug and verification).

Behaviour:
- Reset values:
  - fetch_valid=0; fetch_warp, fetch_pc, fetch_split=0.
  - busy_mask=0; round-robin pointer rr_ptr=0; state=IDLE.
- Eligibility: elig[i] = warp_en[i] & cand_valid[i] & ~busy[i].
- Grant selection:
  - Scan from rr_ptr upward, modulo WARP_NUM; the first eligible warp wins.
  - After a grant to warp g, rr_ptr <= g+1, wrapping to 0 after WARP_NUM-1.
- State machine, evaluated only when rdy=1:
  - IDLE: fetch_valid=0. If any elig bit is set, register the winner into the fetch_* outputs, set fetch_valid=1, set busy[g], and move to ISSUE. This gives 1-cycle latency from eligibility to fetch_valid.
  - ISSUE: fetch_* outputs are held stable while fetch_valid=1 and fetch_ready=0.
    - On fetch_ready=1 with another eligible warp present: load the next winner in the same cycle (back-to-back, one issue per cycle) and stay in ISSUE.
    - On fetch_ready=1 with no eligible warp: clear fetch_valid and go to IDLE.
- Locking:
  - busy[g] is set at grant, not at acceptance.
  - done_valid clears busy[done_warp].
  - If done_valid and a new grant target the same warp in one cycle, the set wins. This case is only legal after release, so the clear is applied first and the new grant then sets the bit.
  - done_valid for a warp that is not busy is ignored.
- Winner evaluation uses the pre-update busy value. A warp released this cycle becomes eligible next cycle.
- warp_en deassert on a warp that is already granted does not cancel the pending request.
- flush (rdy=1): fetch_valid <= 0, busy <= 0, state <= IDLE, rr_ptr unchanged. flush has priority over every other event in that cycle.
- rdy=0: all registers hold and fetch_ready is ignored.
- Asynchronous reset mid-request: all outputs return to their reset values immediately. No request survives.

Optional Feature:
- Macro: GELATO_SCHED_PERF_EN.
- With the macro defined, three extra outputs are present:
  - perf_issue_cnt (32): count of accepted handshakes.
  - perf_stall_cnt (32): cycles with fetch_valid & ~fetch_ready.
  - perf_idle_cnt (32): cycles in IDLE with warp_en != 0.
  - All counters wrap at 2^32, hold when rdy=0, and reset to 0. They are not cleared by flush.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then warp_en=4'b1111, cand_valid=4'b1111, fetch_ready=1, done_valid returning each warp 2 cycles after issue -> issue order 0,1,2,3,0 starting 1 cycle after cand_valid; fetch_pc matches the cand_pc slice.
- Only warp 2 eligible, fetch_ready=0 for 3 cycles -> fetch_valid=1 and fetch_warp=2 held stable for 3 cycles; one acceptance; busy_mask=4'b0100 until done_warp=2.
- Warp 1 issued and never released, cand_valid=4'b0010 -> no second issue of warp 1; fetch_valid=0 after acceptance. Then done_warp=1 -> warp 1 reissued 1 cycle later.
- rr_ptr=3, eligible={0,3} -> warp 3 granted first, then warp 0 (wrap-around).
- flush asserted while fetch_valid=1 and busy_mask=4'b1011 -> next cycle fetch_valid=0, busy_mask=0, state=IDLE.
- rdy=0 during a pending request with fetch_ready=1 -> no acceptance and outputs frozen. With GELATO_SCHED_PERF_EN defined, perf_issue_cnt increments by exactly 1 after rdy returns to 1.
